// File: rtl/regfile_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_sequencer
// Purpose  : Write-side front end for the register file. Write requests
//            (address + data) are taken over a valid/ready handshake and
//            buffered in a small circular FIFO. Each buffered request is then
//            retired as a SETUP -> STROBE -> HOLD sequence on the gated write
//            inputs, so select and data are always stable around every
//            writeEn edge. Requests to register 0 are accepted and dropped.
// Ports    : clk        - clock, all state updates on its rising edge
//            reset      - asynchronous active-high reset
//            reqValid   - request presented
//            reqReady   - request can be accepted (pending < DEPTH)
//            reqAddr    - destination register number
//            reqData    - value to write
//            writeEn    - registered write strobe, one cycle per request
//            writeSel   - registered one-hot destination select
//            writeData  - registered write data
//            pending    - FIFO occupancy, 0..DEPTH
//            busy       - FIFO non-empty or a write sequence in progress
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_sequencer #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         reqValid,
    output logic                         reqReady,
    input  logic [ADDR_WIDTH-1:0]        reqAddr,
    input  logic [DATA_WIDTH-1:0]        reqData,
    output logic                         writeEn,
    output logic [(1<<ADDR_WIDTH)-1:0]   writeSel,
    output logic [DATA_WIDTH-1:0]        writeData,
    output logic [$clog2(DEPTH):0]       pending,
    output logic                         busy
);

    localparam int C_PTR_W = $clog2(DEPTH);
    localparam int C_CNT_W = C_PTR_W + 1;
    localparam int C_SEL_W = 1 << ADDR_WIDTH;

    localparam logic [C_CNT_W-1:0] C_DEPTH   = C_CNT_W'(DEPTH);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE = C_CNT_W'(1);
    localparam logic [C_PTR_W-1:0] C_PTR_ONE = C_PTR_W'(1);
    localparam logic [C_SEL_W-1:0] C_SEL_ONE = C_SEL_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_STROBE = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_mem_addr [DEPTH];
    logic [DATA_WIDTH-1:0]   r_mem_data [DEPTH];
    logic [C_PTR_W-1:0]      r_wr_ptr;
    logic [C_PTR_W-1:0]      r_rd_ptr;
    logic [C_CNT_W-1:0]      r_count;

    logic w_push;
    logic w_pop;

    // Ready depends only on occupancy, never on a same-cycle pop, so the
    // handshake has no combinational path through the FSM.
    assign reqReady = (r_count < C_DEPTH);

    // Register 0 is hardwired zero: the handshake completes but nothing is
    // stored.
    assign w_push = reqValid && reqReady && (reqAddr != '0);

    // The FSM pulls a new entry only from IDLE or HOLD; popping from HOLD
    // gives back-to-back sequences with one write every three cycles.
    assign w_pop = (r_count != '0) && ((r_state == S_IDLE) || (r_state == S_HOLD));

    assign pending = r_count;
    assign busy    = (r_count != '0) || (r_state != S_IDLE);

    // Entry storage needs no reset; occupancy tracking alone decides validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= reqAddr;
            r_mem_data[r_wr_ptr] <= reqData;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Select and data only ever change on IDLE->SETUP, HOLD->SETUP and
    // HOLD->IDLE edges, while writeEn only changes on SETUP->STROBE and
    // STROBE->HOLD edges. The two never coincide, which keeps the gated
    // strobe glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            writeEn   <= 1'b0;
            writeSel  <= '0;
            writeData <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    writeEn <= 1'b0;
                    if (w_pop) begin
                        writeSel  <= C_SEL_ONE << r_mem_addr[r_rd_ptr];
                        writeData <= r_mem_data[r_rd_ptr];
                        r_state   <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    writeEn <= 1'b1;
                    r_state <= S_STROBE;
                end
                S_STROBE: begin
                    writeEn <= 1'b0;
                    r_state <= S_HOLD;
                end
                S_HOLD: begin
                    writeEn <= 1'b0;
                    if (w_pop) begin
                        writeSel  <= C_SEL_ONE << r_mem_addr[r_rd_ptr];
                        writeData <= r_mem_data[r_rd_ptr];
                        r_state   <= S_SETUP;
                    end else begin
                        writeSel <= '0;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    writeEn  <= 1'b0;
                    writeSel <= '0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_sequencer
// Purpose  : Self-checking bench for regfile_write_sequencer. A table of
//            single writes checks exact cycle timing; hand sequences cover
//            fill-to-full, push/pop on the same edge and reset mid-strobe;
//            random traffic is checked by an in-order scoreboard. A negedge
//            monitor checks every strobe, the glitch-free ordering and the
//            occupancy/busy relationships throughout.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_write_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        reqValid;
    logic        reqReady;
    logic [4:0]  reqAddr;
    logic [31:0] reqData;
    logic        writeEn;
    logic [31:0] writeSel;
    logic [31:0] writeData;
    logic [2:0]  pending;
    logic        busy;

    regfile_write_sequencer #(
        .DEPTH      (4),
        .ADDR_WIDTH (5),
        .DATA_WIDTH (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .reqValid  (reqValid),
        .reqReady  (reqReady),
        .reqAddr   (reqAddr),
        .reqData   (reqData),
        .writeEn   (writeEn),
        .writeSel  (writeSel),
        .writeData (writeData),
        .pending   (pending),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] exp_sel;
        logic [31:0] exp_data;
        int          exp_pulses;
    } vec_t;

    int   n_tests  = 0;
    int   n_fail   = 0;
    int   n_pulses = 0;
    int   cyc      = 0;
    wr_t  exp_q[$];
    int   pulse_cyc[$];

    logic        prev_en   = 1'b0;
    logic [31:0] prev_sel  = '0;
    logic [31:0] prev_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: scoreboard, pulse width, glitch-free ordering, invariants.
    always @(negedge clk) begin
        if (reset) begin
            prev_en   = writeEn;
            prev_sel  = writeSel;
            prev_data = writeData;
        end else begin
            if (writeEn !== prev_en) begin
                check("glitch_sel", 64'(writeSel), 64'(prev_sel));
                check("glitch_data", 64'(writeData), 64'(prev_data));
            end
            if (writeEn) begin
                n_pulses++;
                pulse_cyc.push_back(cyc);
                check("pulse_width_prev_en", 64'(prev_en), 64'(0));
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe_sel", 64'(writeSel), 64'(0));
                end else begin
                    wr_t         e;
                    logic [31:0] one;
                    e   = exp_q.pop_front();
                    one = 32'h1;
                    check("sb_sel", 64'(writeSel), 64'(one << e.addr));
                    check("sb_data", 64'(writeData), 64'(e.data));
                end
            end
            check("inv_ready", 64'(reqReady), 64'(pending < 3'd4));
            check("inv_busy", 64'(busy), 64'((pending != 0) || (writeSel != 0)));
            check("inv_onehot", 64'($countones(writeSel) <= 1), 64'(1));
            if (writeEn) check("inv_en_sel", 64'(writeSel != 0), 64'(1));
            prev_en   = writeEn;
            prev_sel  = writeSel;
            prev_data = writeData;
        end
    end

    // Present a request and hold it until accepted; returns 1 time unit
    // after the accepting edge with reqValid dropped.
    task automatic send(input logic [4:0] a, input logic [31:0] d);
        int w;
        w        = 0;
        reqValid = 1'b1;
        reqAddr  = a;
        reqData  = d;
        @(negedge clk);
        while (!reqReady && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!reqReady) begin
            check("send_timeout_ready", 64'(reqReady), 64'(1));
            @(posedge clk);
            #1 reqValid = 1'b0;
        end else begin
            if (a != 0) exp_q.push_back('{addr: a, data: d});
            @(posedge clk);
            #1 reqValid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (busy && w < 300) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("idle_busy", 64'(busy), 64'(0));
        check("idle_sb_empty", 64'(exp_q.size()), 64'(0));
    endtask

    vec_t vecs[6];

    initial begin
        int p0;

        vecs[0] = '{addr: 5'd5,  data: 32'hDEADBEEF, exp_sel: 32'h0000_0020, exp_data: 32'hDEADBEEF, exp_pulses: 1};
        vecs[1] = '{addr: 5'd0,  data: 32'h12345678, exp_sel: 32'h0000_0000, exp_data: 32'h0,        exp_pulses: 0};
        vecs[2] = '{addr: 5'd1,  data: 32'h0000_0001, exp_sel: 32'h0000_0002, exp_data: 32'h0000_0001, exp_pulses: 1};
        vecs[3] = '{addr: 5'd31, data: 32'hFFFF_FFFF, exp_sel: 32'h8000_0000, exp_data: 32'hFFFF_FFFF, exp_pulses: 1};
        vecs[4] = '{addr: 5'd16, data: 32'hA5A5_5A5A, exp_sel: 32'h0001_0000, exp_data: 32'hA5A5_5A5A, exp_pulses: 1};
        vecs[5] = '{addr: 5'd10, data: 32'h0000_0000, exp_sel: 32'h0000_0400, exp_data: 32'h0000_0000, exp_pulses: 1};

        reset    = 1'b1;
        reqValid = 1'b0;
        reqAddr  = '0;
        reqData  = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        check("rst_ready", 64'(reqReady), 64'(1));
        check("rst_en", 64'(writeEn), 64'(0));
        check("rst_sel", 64'(writeSel), 64'(0));
        check("rst_data", 64'(writeData), 64'(0));
        check("rst_pending", 64'(pending), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));

        // Table: single writes with exact cycle timing.
        for (int i = 0; i < 6; i++) begin
            wait_idle();
            p0 = n_pulses;
            send(vecs[i].addr, vecs[i].data);
            if (vecs[i].exp_pulses == 0) begin
                check("zero_pending", 64'(pending), 64'(0));
                check("zero_ready", 64'(reqReady), 64'(1));
                repeat (10) @(posedge clk);
                #1;
                check("zero_no_strobe", 64'(n_pulses - p0), 64'(0));
                check("zero_pending_late", 64'(pending), 64'(0));
                check("zero_ready_late", 64'(reqReady), 64'(1));
            end else begin
                check("e0_pending", 64'(pending), 64'(1));
                check("e0_sel", 64'(writeSel), 64'(0));
                @(posedge clk); #1;
                check("e1_sel", 64'(writeSel), 64'(vecs[i].exp_sel));
                check("e1_data", 64'(writeData), 64'(vecs[i].exp_data));
                check("e1_en", 64'(writeEn), 64'(0));
                @(posedge clk); #1;
                check("e2_en", 64'(writeEn), 64'(1));
                check("e2_sel", 64'(writeSel), 64'(vecs[i].exp_sel));
                @(posedge clk); #1;
                check("e3_en", 64'(writeEn), 64'(0));
                check("e3_sel", 64'(writeSel), 64'(vecs[i].exp_sel));
                @(posedge clk); #1;
                check("e4_sel", 64'(writeSel), 64'(0));
                check("e4_busy", 64'(busy), 64'(0));
                check("e4_pulses", 64'(n_pulses - p0), 64'(vecs[i].exp_pulses));
            end
        end

        // Fill to full: addrs 1..6 back to back.
        wait_idle();
        p0 = n_pulses;
        pulse_cyc.delete();
        for (int i = 1; i <= 6; i++) send(5'(i), 32'(i) * 32'h1111_1111);
        check("full_pending", 64'(pending), 64'(4));
        check("full_ready", 64'(reqReady), 64'(0));
        wait_idle();
        check("full_pulses", 64'(n_pulses - p0), 64'(6));
        if (pulse_cyc.size() == 6) begin
            for (int k = 1; k < 6; k++)
                check("full_spacing", 64'(pulse_cyc[k] - pulse_cyc[k-1]), 64'(3));
        end

        // Push on the same edge as a HOLD->SETUP pop with pending=2.
        wait_idle();
        send(5'd3, 32'h0303_0303);
        send(5'd7, 32'h0707_0707);
        send(5'd9, 32'h0909_0909);
        @(posedge clk); #1;
        check("pp_pending_before", 64'(pending), 64'(2));
        check("pp_en_hold", 64'(writeEn), 64'(0));
        send(5'd12, 32'h0C0C_0C0C);
        check("pp_pending_after", 64'(pending), 64'(2));
        check("pp_sel_next", 64'(writeSel), 64'(32'h0000_0080));
        check("pp_en_setup", 64'(writeEn), 64'(0));
        wait_idle();

        // Reset during STROBE with three entries queued.
        begin
            int w;
            for (int i = 0; i < 5; i++) send(5'(20 + i), 32'hC000_0000 + 32'(i));
            w = 0;
            while (!writeEn && w < 20) begin
                @(posedge clk); #1;
                w++;
            end
            check("mr_strobe_seen", 64'(writeEn), 64'(1));
            check("mr_pending_q", 64'(pending), 64'(3));
            #2 reset = 1'b1;
            #1;
            check("mr_en", 64'(writeEn), 64'(0));
            check("mr_sel", 64'(writeSel), 64'(0));
            check("mr_data", 64'(writeData), 64'(0));
            check("mr_pending", 64'(pending), 64'(0));
            exp_q.delete();
            @(posedge clk);
            @(posedge clk);
            #1 reset = 1'b0;
            check("mr_rel_pending", 64'(pending), 64'(0));
            check("mr_rel_ready", 64'(reqReady), 64'(1));
            check("mr_rel_busy", 64'(busy), 64'(0));
            p0 = n_pulses;
            repeat (8) @(posedge clk);
            #1;
            check("mr_no_strobe", 64'(n_pulses - p0), 64'(0));
        end

        // Random traffic against the scoreboard.
        for (int i = 0; i < 300; i++) begin
            logic [4:0] a;
            a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            send(a, $urandom);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 4)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
